// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register index range through a spare read port and streams each entry out on valid/ready.
module regfile_dump_reader #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] first_idx_i,
  input  logic [ADDR_W-1:0] last_idx_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [WIDTH-1:0]  rf_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_data_o,
  output logic [ADDR_W-1:0] out_idx_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, SEND = 2'd2, DONE = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d, out_idx_q, idx_inc;
  logic [WIDTH-1:0]  out_data_q;
  logic              out_last_q, at_last, skip, capture;
  assign idx_inc = idx_q + ADDR_W'(1);
  assign at_last = idx_q == last_q;
  assign skip    = SKIP_ZERO != 0 && idx_q == '0;
  assign capture = state_q == READ && !skip;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (start_i && !abort_i) begin
        state_d = READ;
        idx_d   = first_idx_i;
        last_d  = last_idx_i;
      end
      READ: begin
        state_d = !skip ? SEND : at_last ? DONE : READ;
        idx_d   = skip && !at_last ? idx_inc : idx_q;
      end
      SEND: if (out_ready_i) begin
        state_d = at_last ? DONE : READ;
        idx_d   = at_last ? idx_q : idx_inc;
      end
      default: state_d = IDLE;
    endcase
    // abort wins over a same-cycle handshake, so that beat is never delivered
    if (abort_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      if (capture) begin
        out_data_q <= rf_rdata_i;
        out_idx_q  <= idx_q;
        out_last_q <= at_last;
      end
    end
  end
  assign rf_addr_o   = idx_q;
  assign out_valid_o = state_q == SEND;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = state_q != IDLE;
  assign done_o      = state_q == DONE;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: scoreboard bench for the dump reader, with a second instance built with SKIP_ZERO=1.
module tb_regfile_dump_reader;
  typedef struct packed {logic [4:0] idx; logic [31:0] data; logic last;} beat_t;
  logic        clk_i = 0, reset_i = 0, start_i = 0, abort_i = 0, out_ready_i = 0;
  logic [4:0]  first_idx_i = '0, last_idx_i = '0;
  logic [31:0] rf [32];
  logic [4:0]  a_addr, a_idx, b_addr, b_idx;
  logic [31:0] a_rdata, a_data, b_rdata, b_data;
  logic        a_valid, a_last, a_busy, a_done, b_valid, b_last, b_busy, b_done;
  int          checks = 0, errors = 0, cyc = 0, hs_cyc = -10, done_cyc = -10;
  int          done_cnt = 0, b_beats = 0, b_done_cnt = 0;
  beat_t       exp_q[$];
  always #5 clk_i = ~clk_i;
  assign a_rdata = rf[a_addr];
  assign b_rdata = rf[b_addr];
  regfile_dump_reader #(.WIDTH(32), .ADDR_W(5), .SKIP_ZERO(0)) dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .first_idx_i(first_idx_i),
    .last_idx_i(last_idx_i), .abort_i(abort_i), .rf_addr_o(a_addr), .rf_rdata_i(a_rdata),
    .out_valid_o(a_valid), .out_ready_i(out_ready_i), .out_data_o(a_data), .out_idx_o(a_idx),
    .out_last_o(a_last), .busy_o(a_busy), .done_o(a_done));
  regfile_dump_reader #(.WIDTH(32), .ADDR_W(5), .SKIP_ZERO(1)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .first_idx_i(first_idx_i),
    .last_idx_i(last_idx_i), .abort_i(abort_i), .rf_addr_o(b_addr), .rf_rdata_i(b_rdata),
    .out_valid_o(b_valid), .out_ready_i(out_ready_i), .out_data_o(b_data), .out_idx_o(b_idx),
    .out_last_o(b_last), .busy_o(b_busy), .done_o(b_done));
  // one clock cycle: observe mid-cycle, pop the scoreboard on a handshake, return just after the edge
  task automatic step();
    beat_t e;
    @(negedge clk_i);
    cyc++;
    if (!reset_i && !abort_i && out_ready_i && a_valid) begin
      checks++;
      hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: got unexpected idx=%0d data=%h, required no beat", a_idx, a_data);
      end else begin
        e = exp_q.pop_front();
        if ({a_idx, a_data, a_last} !== e) begin
          errors++;
          $display("FAIL beat: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                   a_idx, a_data, a_last, e.idx, e.data, e.last);
        end
      end
    end
    if (!reset_i && !abort_i && out_ready_i && b_valid) b_beats++;
    if (a_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (b_done) b_done_cnt++;
    @(posedge clk_i);
    #1;
  endtask
  task automatic new_scenario();
    cyc = 0; hs_cyc = -10; done_cyc = -10; done_cnt = 0; b_beats = 0; b_done_cnt = 0;
    exp_q.delete();
  endtask
  task automatic expect_beat(input logic [4:0] i, input logic l);
    exp_q.push_back({i, rf[i], l});
  endtask
  task automatic launch(input logic [4:0] f, input logic [4:0] l);
    first_idx_i = f;
    last_idx_i  = l;
    start_i     = 1;
    step();
    start_i     = 0;
  endtask
  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) step();
  endtask
  task automatic test_reset();
    for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 + 32'(i);
    rf[0] = '0; rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
    #1 reset_i = 1;
    #1;
    checks++;
    if ({a_addr, a_valid, a_data, a_idx, a_last, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL reset_a: got addr=%0d valid=%b data=%h idx=%0d last=%b busy=%b done=%b, required all 0",
               a_addr, a_valid, a_data, a_idx, a_last, a_busy, a_done);
    end
    checks++;
    if ({b_addr, b_valid, b_data, b_idx, b_last, b_busy, b_done} !== '0) begin
      errors++;
      $display("FAIL reset_b: got addr=%0d valid=%b data=%h busy=%b, required all 0", b_addr, b_valid, b_data, b_busy);
    end
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset_i = 0;
    step();
    checks++;
    if ({a_valid, a_busy, a_done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got valid/busy/done=%b%b%b, required 000", a_valid, a_busy, a_done);
    end
  endtask
  task automatic test_basic();
    new_scenario();
    out_ready_i = 1;
    expect_beat(1, 0); expect_beat(2, 0); expect_beat(3, 1);
    launch(1, 3);
    checks++;
    if ({a_valid, a_busy} !== 2'b01) begin
      errors++;
      $display("FAIL latency_early: got valid=%b busy=%b one edge after start, required valid=0 busy=1", a_valid, a_busy);
    end
    step();
    checks++;
    if ({a_valid, a_idx, a_addr} !== {1'b1, 5'd1, 5'd1}) begin
      errors++;
      $display("FAIL latency: got valid=%b idx=%0d addr=%0d two edges after start, required 1/1/1", a_valid, a_idx, a_addr);
    end
    run_to_done(40);
    checks++;
    if (done_cnt != 1 || done_cyc != hs_cyc + 1) begin
      errors++;
      $display("FAIL done_timing: got done_cnt=%0d done_cyc=%0d, required 1 at cycle %0d", done_cnt, done_cyc, hs_cyc + 1);
    end
    checks++;
    if ({a_done, a_busy} !== 2'b00 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_end: got done=%b busy=%b pending=%0d, required 0 0 0", a_done, a_busy, exp_q.size());
    end
    step();
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL done_pulse: got %0d done cycles, required 1", done_cnt);
    end
  endtask
  task automatic test_wrap();
    new_scenario();
    rf[30] = 32'h3030_3030; rf[31] = 32'h3131_3131;
    expect_beat(30, 0); expect_beat(31, 0); expect_beat(0, 0); expect_beat(1, 1);
    out_ready_i = 1;
    launch(30, 1);
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin
      out_ready_i = 1'($urandom_range(0, 1));
      step();
    end
    out_ready_i = 1;
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap: got done_cnt=%0d pending=%0d, required 1 and 0", done_cnt, exp_q.size());
    end
  endtask
  task automatic test_skip_zero();
    new_scenario();
    out_ready_i = 1;
    expect_beat(0, 1);
    launch(0, 0);
    checks++;
    if ({b_busy, b_valid} !== 2'b10) begin
      errors++;
      $display("FAIL skip_read: got busy=%b valid=%b, required 1 0", b_busy, b_valid);
    end
    step();
    checks++;
    if (b_done !== 1'b1) begin
      errors++;
      $display("FAIL skip_done: got done=%b two edges after start, required 1", b_done);
    end
    step();
    checks++;
    if ({b_done, b_busy} !== 2'b00) begin
      errors++;
      $display("FAIL skip_idle: got done=%b busy=%b, required 0 0", b_done, b_busy);
    end
    run_to_done(20);
    checks++;
    if (b_beats != 0 || b_done_cnt != 1 || done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL skip_single: got b_beats=%0d b_done=%0d a_done=%0d pending=%0d, required 0 1 1 0",
               b_beats, b_done_cnt, done_cnt, exp_q.size());
    end
    new_scenario();
    expect_beat(31, 0); expect_beat(0, 0); expect_beat(1, 1);
    launch(31, 1);
    run_to_done(40);
    checks++;
    if (b_beats != 2 || b_done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL skip_range: got b_beats=%0d b_done=%0d pending=%0d, required 2 1 0", b_beats, b_done_cnt, exp_q.size());
    end
  endtask
  task automatic test_stall();
    int stalls = 0;
    new_scenario();
    out_ready_i = 1;
    expect_beat(1, 0); expect_beat(2, 0); expect_beat(3, 1);
    launch(1, 3);
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      if (a_valid && a_idx == 2 && stalls < 5) begin
        out_ready_i = 0;
        if (stalls == 0) rf[2] = 32'hAA;
        stalls++;
      end else out_ready_i = 1;
      step();
      if (!out_ready_i) begin
        checks++;
        if ({a_valid, a_idx, a_data} !== {1'b1, 5'd2, 32'h22}) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b idx=%0d data=%h, required 1 2 00000022", a_valid, a_idx, a_data);
        end
      end
    end
    out_ready_i = 1;
    rf[2] = 32'h22;
    checks++;
    if (stalls != 5 || done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_end: got stalls=%0d done_cnt=%0d pending=%0d, required 5 1 0", stalls, done_cnt, exp_q.size());
    end
  endtask
  task automatic test_abort();
    new_scenario();
    out_ready_i = 1;
    expect_beat(4, 0);
    launch(4, 7);
    for (int i = 0; i < 20 && !(a_valid && a_idx == 5); i++) step();
    abort_i = 1;
    step();
    abort_i = 0;
    checks++;
    if ({a_valid, a_busy, b_busy} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle: got valid=%b busy=%b b_busy=%b, required 0 0 0", a_valid, a_busy, b_busy);
    end
    step();
    step();
    checks++;
    if (done_cnt != 0 || exp_q.size() != 0 || hs_cyc < 0) begin
      errors++;
      $display("FAIL abort_nodone: got done_cnt=%0d pending=%0d hs_cyc=%0d, required 0 0 >=0", done_cnt, exp_q.size(), hs_cyc);
    end
    start_i = 1; abort_i = 1;
    step();
    start_i = 0; abort_i = 0;
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: got busy=%b, required 0", a_busy);
    end
    expect_beat(7, 1);
    launch(7, 7);
    run_to_done(20);
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart: got done_cnt=%0d pending=%0d, required 1 0", done_cnt, exp_q.size());
    end
  endtask
  task automatic test_reset_mid();
    new_scenario();
    out_ready_i = 0;
    launch(8, 10);
    first_idx_i = 20; last_idx_i = 20; start_i = 1;
    step();
    start_i = 0;
    checks++;
    if ({a_valid, a_busy, a_idx, a_data} !== {2'b11, 5'd8, rf[8]}) begin
      errors++;
      $display("FAIL start_busy: got valid=%b busy=%b idx=%0d data=%h, required 1 1 8 %h", a_valid, a_busy, a_idx, a_data, rf[8]);
    end
    step();
    reset_i = 1;
    #2;
    checks++;
    if ({a_addr, a_valid, a_data, a_idx, a_last, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL async_reset: got addr=%0d valid=%b data=%h idx=%0d busy=%b, required all 0", a_addr, a_valid, a_data, a_idx, a_busy);
    end
    @(posedge clk_i);
    #1 reset_i = 0;
    out_ready_i = 1;
    step();
    step();
    checks++;
    if (done_cnt != 0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_nodone: got done_cnt=%0d busy=%b, required 0 0", done_cnt, a_busy);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_skip_zero();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
